// File: rtl/sal_ref_timer.sv
// Per-rank auto-refresh timer: counts tREFI intervals and tracks owed refreshes per bank.
// Optional build macro SAL_REF_STAGGER_EN spreads the bank ticks across the interval.
module sal_ref_timer #(
  parameter int NUM_BANKS    = 8,
  parameter int TREFI        = 1560,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ref_en_i,
  output logic [NUM_BANKS-1:0]   ref_req_o,
  input  logic [NUM_BANKS-1:0]   ref_gnt_i,
  output logic [NUM_BANKS-1:0]   urgent_o,
  output logic                   ovf_o,
  output logic [4*NUM_BANKS-1:0] owed_o
);

  localparam int CW = $clog2(TREFI);
  localparam logic [CW-1:0] CNT_LAST = CW'(TREFI - 1);
  localparam logic [3:0] OWED_MAX = 4'(MAX_POSTPONE);

  logic [CW-1:0]        cnt;
  logic [3:0]           owed [NUM_BANKS];
  logic                 ovf;
  logic [NUM_BANKS-1:0] tick;
  logic [NUM_BANKS-1:0] gnt;

  // Tick and accepted-grant decode; grants against a zero count are dropped here
  always_comb begin
    tick = '0;
    gnt  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef SAL_REF_STAGGER_EN
      tick[b] = ref_en_i && (cnt == CW'(b * (TREFI / NUM_BANKS)));
`else
      tick[b] = ref_en_i && (cnt == CNT_LAST);
`endif
      gnt[b] = ref_gnt_i[b] && (owed[b] != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        owed[b] <= 4'd0;
      end
    end else begin
      if (!ref_en_i || cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A tick and a grant together cancel out, so only one-sided events move the count
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (tick[b] && !gnt[b]) begin
          if (owed[b] == OWED_MAX) begin
            ovf <= 1'b1;
          end else begin
            owed[b] <= owed[b] + 4'd1;
          end
        end else if (gnt[b] && !tick[b]) begin
          owed[b] <= owed[b] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    ref_req_o = '0;
    urgent_o  = '0;
    owed_o    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ref_req_o[b]      = (owed[b] != 4'd0);
      urgent_o[b]       = (owed[b] == OWED_MAX);
      owed_o[4*b +: 4]  = owed[b];
    end
  end

  assign ovf_o = ovf;

endmodule

// File: tb/tb_sal_ref_timer.sv
// Directed self-checking bench for sal_ref_timer (TREFI=16, NUM_BANKS=4, MAX_POSTPONE=8).
// Covers both the default build and the SAL_REF_STAGGER_EN build.
module tb_sal_ref_timer;

  logic        clk;
  logic        rst;
  logic        ref_en_i;
  logic [3:0]  ref_req_o;
  logic [3:0]  ref_gnt_i;
  logic [3:0]  urgent_o;
  logic        ovf_o;
  logic [15:0] owed_o;

  int vec_count  = 0;
  int miss_count = 0;

  sal_ref_timer #(
    .NUM_BANKS(4),
    .TREFI(16),
    .MAX_POSTPONE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ref_en_i(ref_en_i),
    .ref_req_o(ref_req_o),
    .ref_gnt_i(ref_gnt_i),
    .urgent_o(urgent_o),
    .ovf_o(ovf_o),
    .owed_o(owed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  // Holds the given inputs for n clock edges; outputs are then stable 1 time unit after the last edge
  task automatic applyStimulus(input logic en, input logic [3:0] gnt, input int n);
    ref_en_i  = en;
    ref_gnt_i = gnt;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    ref_gnt_i = 4'b0000;
  endtask

  task automatic doReset(input logic en, input logic [3:0] gnt);
    rst = 1'b1;
    applyStimulus(en, gnt, 1);
    rst = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_req"},    32'(ref_req_o), 32'h0);
    checkOutput({tag, "_urgent"}, 32'(urgent_o),  32'h0);
    checkOutput({tag, "_ovf"},    32'(ovf_o),     32'h0);
    checkOutput({tag, "_owed"},   32'(owed_o),    32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    ref_en_i  = 1'b0;
    ref_gnt_i = 4'b0000;
    applyStimulus(1'b0, 4'b0000, 2);
    rst = 1'b0;
    checkCleared("reset");

`ifdef SAL_REF_STAGGER_EN
    doReset(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 1);
    checkOutput("stg_bank0_tick", 32'(owed_o), 32'h0001);
    applyStimulus(1'b1, 4'b0000, 3);
    checkOutput("stg_hold_cnt3", 32'(owed_o), 32'h0001);
    applyStimulus(1'b1, 4'b0000, 1);
    checkOutput("stg_bank1_tick", 32'(owed_o), 32'h0011);
    applyStimulus(1'b1, 4'b0000, 4);
    checkOutput("stg_bank2_tick", 32'(owed_o), 32'h0111);
    applyStimulus(1'b1, 4'b0000, 4);
    checkOutput("stg_bank3_tick", 32'(owed_o), 32'h1111);
    checkOutput("stg_req_all",    32'(ref_req_o), 32'hf);
    applyStimulus(1'b1, 4'b0100, 1);
    checkOutput("stg_gnt2_req",  32'(ref_req_o), 32'hb);
    applyStimulus(1'b1, 4'b0100, 1);
    checkOutput("stg_gnt2_again", 32'(owed_o), 32'h1011);
    applyStimulus(1'b1, 4'b0000, 2);
    checkOutput("stg_bank0_second", 32'(owed_o), 32'h1012);
`else
    // First interval after enable: ticks land on edge 16
    doReset(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 15);
    checkOutput("pre_tick_req", 32'(ref_req_o), 32'h0);
    applyStimulus(1'b1, 4'b0000, 1);
    checkOutput("first_tick_req",  32'(ref_req_o), 32'hf);
    checkOutput("first_tick_owed", 32'(owed_o),    32'h1111);
    applyStimulus(1'b1, 4'b0100, 1);
    checkOutput("gnt2_req",  32'(ref_req_o), 32'hb);
    checkOutput("gnt2_owed", 32'(owed_o),    32'h1011);
    applyStimulus(1'b1, 4'b0100, 1);
    checkOutput("gnt2_repeat_owed", 32'(owed_o), 32'h1011);

    // Saturation: ticks every 16 edges after a fresh reset
    doReset(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 127);
    checkOutput("seven_owed",   32'(owed_o),   32'h7777);
    checkOutput("seven_urgent", 32'(urgent_o), 32'h0);
    applyStimulus(1'b1, 4'b0000, 1);
    checkOutput("eight_owed",   32'(owed_o),   32'h8888);
    checkOutput("eight_urgent", 32'(urgent_o), 32'hf);
    checkOutput("eight_ovf",    32'(ovf_o),    32'h0);
    applyStimulus(1'b1, 4'b0000, 15);
    applyStimulus(1'b1, 4'b0001, 1);
    checkOutput("ninth_owed", 32'(owed_o), 32'h8888);
    checkOutput("ninth_ovf",  32'(ovf_o),  32'h1);

    // Bring bank 1 down to 3, then tick and grant it together
    applyStimulus(1'b1, 4'b0010, 5);
    checkOutput("bank1_three_owed",   32'(owed_o),   32'h8838);
    checkOutput("bank1_three_urgent", 32'(urgent_o), 32'hd);
    applyStimulus(1'b1, 4'b0000, 10);
    applyStimulus(1'b1, 4'b0010, 1);
    checkOutput("tick_gnt_owed", 32'(owed_o),    32'h8838);
    checkOutput("tick_gnt_req",  32'(ref_req_o), 32'hf);
    checkOutput("ovf_sticky",    32'(ovf_o),     32'h1);

    // Drain to 3 everywhere, then two more ticks give 5 per bank
    applyStimulus(1'b1, 4'b1101, 5);
    checkOutput("drain_owed", 32'(owed_o), 32'h3333);
    applyStimulus(1'b1, 4'b0000, 27);
    checkOutput("five_owed", 32'(owed_o), 32'h5555);
    checkOutput("five_ovf",  32'(ovf_o),  32'h1);

    // Reset with a coincident grant, then enable low for 40 cycles
    doReset(1'b1, 4'b1111);
    checkCleared("mid_reset");
    applyStimulus(1'b0, 4'b0000, 40);
    checkOutput("disabled_req",  32'(ref_req_o), 32'h0);
    checkOutput("disabled_owed", 32'(owed_o),    32'h0);
    applyStimulus(1'b1, 4'b0000, 15);
    checkOutput("reenable_pre_req", 32'(ref_req_o), 32'h0);
    applyStimulus(1'b1, 4'b0000, 1);
    checkOutput("reenable_tick_req", 32'(ref_req_o), 32'hf);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
